// File: rtl/pipe_flush_sched_if.sv
// rtl/pipe_flush_sched_if.sv - stall/flush scheduler bus; PIPE_PERF_CNT_EN adds perf counter outputs
interface pipe_flush_sched_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_dcache;
    logic        exception_flag;
    logic [4:0]  exception_type;
    logic [31:0] cp0_epc_i;
    logic [31:0] ebase_i;
    logic        pred_flag;
    logic [31:0] pred_target_i;
    logic [3:0]  stall;
    logic        flush;
    logic        flush_cause;
    logic [31:0] epc_o;
    logic        flush_to_ibuffer;
    logic        busy;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_dcache,
        output exception_flag, exception_type, cp0_epc_i, ebase_i, pred_flag, pred_target_i,
`ifdef PIPE_PERF_CNT_EN
        input  stall_cycles, flush_count,
`endif
        input  stall, flush, flush_cause, epc_o, flush_to_ibuffer, busy
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_dcache,
        input  exception_flag, exception_type, cp0_epc_i, ebase_i, pred_flag, pred_target_i,
`ifdef PIPE_PERF_CNT_EN
        output stall_cycles, flush_count,
`endif
        output stall, flush, flush_cause, epc_o, flush_to_ibuffer, busy
    );
endinterface

// File: rtl/pipe_flush_sched.sv
// rtl/pipe_flush_sched.sv - 4-stage pipe stall/flush scheduler; PIPE_PERF_CNT_EN adds perf counters
module pipe_flush_sched #(
    parameter int unsigned HOLDOFF_CYCLES = 2,
    parameter logic [31:0] EXC_OFFSET     = 32'h180,
    parameter logic [4:0]  ERET_TYPE      = 5'h0E
) (
    input  logic               clk,
    input  logic               rst,
    pipe_flush_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, FLUSH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        cause_q, cause_d;
    logic [31:0] target_q, target_d;
    logic [31:0] exc_target;
    logic [3:0]  stall_req;

    assign exc_target = (bus.exception_type == ERET_TYPE) ? bus.cp0_epc_i
                                                          : bus.ebase_i + EXC_OFFSET;

    // Priority-encode stall requests; a stalled stage also holds every younger stage
    always_comb begin
        stall_req = 4'b0000;
        if (bus.stallreq_from_dcache)  stall_req = 4'b1111;
        else if (bus.stallreq_from_ex) stall_req = 4'b0111;
        else if (bus.stallreq_from_id) stall_req = 4'b0011;
        else if (bus.stallreq_from_if) stall_req = 4'b0001;
    end

    // State, holdoff counter and captured redirect registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            cause_q  <= 1'b0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    // Next-state: capture redirect, defer it under dcache stall, then flush and hold off
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cause_d  = cause_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (bus.exception_flag) begin
                    cause_d  = 1'b1;
                    target_d = exc_target;
                    state_d  = bus.stallreq_from_dcache ? WAIT : FLUSH;
                end else if (bus.pred_flag) begin
                    cause_d  = 1'b0;
                    target_d = bus.pred_target_i;
                    state_d  = bus.stallreq_from_dcache ? WAIT : FLUSH;
                end
            end
            WAIT: begin
                // An exception outranks a pending mispredict but never another exception
                if (bus.exception_flag && !cause_q) begin
                    cause_d  = 1'b1;
                    target_d = exc_target;
                end
                if (!bus.stallreq_from_dcache) state_d = FLUSH;
            end
            FLUSH: begin
                state_d = HOLD;
                cnt_d   = 4'(HOLDOFF_CYCLES);
            end
            HOLD: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.stall            = (!rst || state_q == FLUSH) ? 4'b0000 : stall_req;
    assign bus.flush            = (state_q == FLUSH);
    assign bus.flush_cause      = cause_q;
    assign bus.epc_o            = target_q;
    assign bus.flush_to_ibuffer = ~rst | bus.flush;
    assign bus.busy             = (state_q != IDLE);

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    // Saturating stall-cycle and flush event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else begin
            if (bus.stall != 4'b0000 && stall_cycles_q != 32'hFFFF_FFFF)
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (bus.flush && flush_count_q != 16'hFFFF)
                flush_count_q <= flush_count_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`endif
endmodule
